imem_loader: RTL and testbench

- Parametrised instruction-memory block with a boot-load path; the successor to the fixed 32-word instruction ROM that feeds the cpu fetch port.
- A host streams program words in over a valid/ready handshake while the block holds the cpu in reset. The block then releases the cpu and serves fetches from the loaded image.
- It sits between the top-level computer, the cpu fetch port (pc in, instruction out) and an external load interface.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_dp_ram.sv | 24 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and defaults for the instruction-memory loader
package imem_pkg;

    // Loader sequencing: hold cpu, stream image, settle one cycle, run.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // Instruction presented to the cpu while it is held in reset.
    localparam logic [15:0] IMEM_NOP_WORD = 16'h0000;

endpackage

// File: rtl/imem_dp_ram.sv
// rtl/imem_dp_ram.sv - one-write one-read synchronous RAM, registered read, read-before-write
module imem_dp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write and registered read share the edge; a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with host boot-load path and cpu reset control
module imem_loader
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   loaded_words,
    output logic              load_full
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W:0]   ptr;
    logic              instr_en;
    logic              xfer;
    logic [DATA_W-1:0] ram_rdata;

    // A restart or reset in the same cycle discards the offered word.
    assign xfer = (state == ST_LOAD) && load_valid && load_ready && !load_start && !reset;

    imem_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (xfer),
        .waddr (ptr[ADDR_W-1:0]),
        .wdata (load_data),
        .raddr (pc),
        .rdata (ram_rdata)
    );

    // Both inputs of this select are flops, so instr has no path from pc or state inputs.
    assign instr = instr_en ? ram_rdata : NOP_WORD;

    // Sequencer: owns cpu hold, load handshake, write pointer, counters and fetch masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_HOLD;
            ptr          <= '0;
            cpu_reset    <= 1'b1;
            load_ready   <= 1'b0;
            instr_en     <= 1'b0;
            loaded_words <= '0;
            load_full    <= 1'b0;
        end else begin
            // Fetch data is only exposed while the cpu stays out of reset across this edge.
            instr_en <= (state == ST_RUN) && !load_start;
            case (state)
                ST_HOLD: begin
                    if (load_start) begin
                        state        <= ST_LOAD;
                        ptr          <= '0;
                        loaded_words <= '0;
                        load_full    <= 1'b0;
                        load_ready   <= 1'b1;
                    end else if (run_start) begin
                        state <= ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        ptr          <= '0;
                        loaded_words <= '0;
                        load_full    <= 1'b0;
                    end else if (xfer) begin
                        ptr <= ptr + ONE;
                        if (loaded_words != DEPTH_CNT) begin
                            loaded_words <= loaded_words + ONE;
                        end
                        if (load_last) begin
                            state      <= ST_DONE;
                            load_ready <= 1'b0;
                        end else if (ptr == LAST_PTR) begin
                            state      <= ST_DONE;
                            load_ready <= 1'b0;
                            load_full  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_RUN;
                    cpu_reset <= 1'b0;
                end
                ST_RUN: begin
                    if (load_start) begin
                        state        <= ST_LOAD;
                        cpu_reset    <= 1'b1;
                        load_ready   <= 1'b1;
                        ptr          <= '0;
                        loaded_words <= '0;
                        load_full    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        run_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [5:0]  pc;
    logic [15:0] instr;
    logic        cpu_reset;
    logic [6:0]  loaded_words;
    logic        load_full;

    int tests = 0;
    int fails = 0;

    logic [15:0] model_mem [64];
    int          wptr;
    logic [15:0] sb [$];

    typedef struct {
        logic [5:0]  pc;
        logic [15:0] exp;
    } fetch_vec_t;

    fetch_vec_t tbl [6];

    imem_loader #(
        .DATA_W   (16),
        .ADDR_W   (6),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .run_start    (run_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .pc           (pc),
        .instr        (instr),
        .cpu_reset    (cpu_reset),
        .loaded_words (loaded_words),
        .load_full    (load_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wptr = 0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        check("load_ready_in_load", load_ready, 1);
        tick();
        model_mem[wptr] = d;
        wptr++;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [5:0] a, input string nm);
        logic [15:0] e;
        pc = a;
        sb.push_back(model_mem[a]);
        tick();
        e = sb.pop_front();
        check(nm, instr, e);
    endtask

    initial begin
        tbl[0] = '{pc: 6'd63, exp: 16'd189};
        tbl[1] = '{pc: 6'd0,  exp: 16'd0};
        tbl[2] = '{pc: 6'd1,  exp: 16'd3};
        tbl[3] = '{pc: 6'd32, exp: 16'd96};
        tbl[4] = '{pc: 6'd10, exp: 16'd30};
        tbl[5] = '{pc: 6'd62, exp: 16'd186};

        reset = 1'b0; load_start = 1'b0; run_start = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; pc = '0;
        wptr = 0;

        // Reset state
        do_reset();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_load_ready", load_ready, 0);
        check("rst_instr", instr, 16'h0000);
        check("rst_loaded_words", loaded_words, 0);
        check("rst_load_full", load_full, 0);

        // Three-word image ended by load_last
        pulse_load_start();
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b1);
        check("t1_done_cpu_reset", cpu_reset, 1);
        check("t1_done_load_ready", load_ready, 0);
        check("t1_loaded_words", loaded_words, 3);
        check("t1_load_full", load_full, 0);
        tick();
        check("t1_run_cpu_reset", cpu_reset, 0);
        check("t1_first_run_instr_nop", instr, 16'h0000);
        fetch(6'd1, "t1_fetch_pc1");
        check("t1_fetch_pc1_const", instr, 16'h2222);

        // Full 64-word image, no load_last
        do_reset();
        pulse_load_start();
        for (int i = 0; i < 64; i++) begin
            send_word(16'(i * 3), 1'b0);
        end
        check("t2_load_ready_dropped", load_ready, 0);
        check("t2_load_full", load_full, 1);
        check("t2_loaded_words", loaded_words, 64);
        check("t2_done_cpu_reset", cpu_reset, 1);
        tick();
        check("t2_run_cpu_reset", cpu_reset, 0);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] e;
            pc = tbl[i].pc;
            sb.push_back(tbl[i].exp);
            tick();
            e = sb.pop_front();
            check($sformatf("t2_tbl_fetch_%0d", i), instr, e);
        end

        // Stall of 10 cycles after word 2
        do_reset();
        pulse_load_start();
        send_word(16'h5000, 1'b0);
        send_word(16'h5001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_stall_loaded_words", loaded_words, 2);
            check("t3_stall_load_ready", load_ready, 1);
        end
        for (int i = 2; i < 8; i++) begin
            send_word(16'h5000 + 16'(i), i == 7);
        end
        check("t3_loaded_words", loaded_words, 8);
        check("t3_load_full", load_full, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            fetch(6'(i), "t3_fetch");
        end

        // Reset after 5 of 8 words
        do_reset();
        pulse_load_start();
        for (int i = 0; i < 5; i++) begin
            send_word(16'h7000 + 16'(i), 1'b0);
        end
        check("t4_mid_loaded_words", loaded_words, 5);
        do_reset();
        check("t4_cpu_reset", cpu_reset, 1);
        check("t4_loaded_words", loaded_words, 0);
        check("t4_load_ready", load_ready, 0);
        check("t4_load_full", load_full, 0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("t4_done_cpu_reset", cpu_reset, 1);
        tick();
        check("t4_run_cpu_reset", cpu_reset, 0);
        fetch(6'd4, "t4_fetch_pc4");
        check("t4_fetch_pc4_const", instr, 16'h7004);
        fetch(6'd5, "t4_fetch_pc5_kept");

        // Reload from RUN
        pc = 6'd2;
        pulse_load_start();
        check("t5_cpu_reset", cpu_reset, 1);
        check("t5_instr_nop", instr, 16'h0000);
        check("t5_loaded_words", loaded_words, 0);
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBBBB, 1'b1);
        check("t5_loaded_words_2", loaded_words, 2);
        tick();
        fetch(6'd0, "t5_fetch_0");
        fetch(6'd1, "t5_fetch_1");
        fetch(6'd2, "t5_fetch_2_kept");
        check("t5_fetch_2_const", instr, 16'h7002);

        // Both starts in HOLD, restart inside LOAD, writes ignored in RUN
        do_reset();
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        check("t6_both_load_ready", load_ready, 1);
        check("t6_both_cpu_reset", cpu_reset, 1);
        send_word(16'h0BAD, 1'b0);
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        wptr = 0;
        check("t6_restart_loaded_words", loaded_words, 0);
        check("t6_restart_load_ready", load_ready, 1);
        send_word(16'h1234, 1'b1);
        check("t6_loaded_words", loaded_words, 1);
        tick();
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        run_start  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch(6'd0, "t6_run_fetch_0");
            check("t6_run_load_ready", load_ready, 0);
            check("t6_run_cpu_reset", cpu_reset, 0);
            check("t6_run_loaded_words", loaded_words, 1);
        end
        fetch(6'd1, "t6_run_fetch_1");
        check("t6_run_fetch_1_const", instr, 16'hBBBB);
        load_valid = 1'b0;
        run_start  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
